// File: rtl/timer_dev.sv
// ============================================================================
// Module   : timer_dev
// Brief    : Memory-mapped countdown timer with one-shot / auto-reload IRQ.
//            Optional macro TIMER_MODE1_EN enables auto-reload (mode 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DI,
    output logic [31:0] DO,
    output logic        IRQ
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_flag;

    logic        w_enable;
    logic        w_mode1;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_load;
    logic        w_dec;
    logic        w_expire;
    logic        w_hw_dis;
    logic        w_hw_ack;

    assign w_enable    = r_ctrl[0];
    assign w_wr_ctrl   = WE && (Addr == c_ADDR_CTRL);
    assign w_wr_preset = WE && (Addr == c_ADDR_PRESET);

`ifdef TIMER_MODE1_EN
    assign w_mode1 = (r_ctrl[2:1] == 2'd1);
`else
    assign w_mode1 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_enable) w_next_state = S_LOAD;
            S_LOAD: w_next_state = S_CNT;
            S_CNT: begin
                if (!w_enable) begin
                    w_next_state = S_IDLE;
                end else if (r_count <= 32'd1) begin
                    w_next_state = S_INT;
                end
            end
            S_INT:   w_next_state = w_mode1 ? S_LOAD : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_expire = 1'b0;
        w_hw_dis = 1'b0;
        w_hw_ack = 1'b0;
        case (r_state)
            S_LOAD: w_load = 1'b1;
            S_CNT: begin
                w_dec    = w_enable && (r_count > 32'd1);
                w_expire = w_enable && (r_count <= 32'd1);
            end
            S_INT: begin
                w_hw_dis = !w_mode1;
                w_hw_ack = w_mode1;
            end
            default: ;
        endcase
    end

    // Software CTRL write beats the hardware Enable clear; flag set beats the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl   <= 4'd0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
            r_flag   <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= DI[3:0];
            end else if (w_hw_dis) begin
                r_ctrl[0] <= 1'b0;
            end

            if (w_wr_preset) begin
                r_preset <= DI;
            end

            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= r_count - 32'd1;
            end else if (w_expire) begin
                r_count <= 32'd0;
            end

            if (w_expire) begin
                r_flag <= 1'b1;
            end else if (w_wr_ctrl || w_hw_ack) begin
                r_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        case (Addr)
            c_ADDR_CTRL:   DO = {28'd0, r_ctrl};
            c_ADDR_PRESET: DO = r_preset;
            c_ADDR_COUNT:  DO = r_count;
            default:       DO = 32'd0;
        endcase
    end

    assign IRQ = r_flag & r_ctrl[3];

endmodule

`default_nettype wire

// File: tb/tb_timer_dev.sv
// ============================================================================
// Module   : tb_timer_dev
// Brief    : Directed self-checking bench for timer_dev.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DI;
    logic [31:0] DO;
    logic        IRQ;

    int tests;
    int fails;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .DI    (DI),
        .DO    (DO),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DI   = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = DO;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        logic        exp_irq;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        Addr  = 2'd0;
        WE    = 1'b0;
        DI    = 32'd0;

        // ---- reset state ----
        do_reset();
        rd(2'd0, v); chk("rst_ctrl", v, 32'd0);
        rd(2'd1, v); chk("rst_preset", v, 32'd0);
        rd(2'd2, v); chk("rst_count", v, 32'd0);
        chk("rst_irq", {31'd0, IRQ}, 32'd0);

        // ---- one-shot, PRESET=5: COUNT 5..0, IRQ at E0+7 ----
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            rd(2'd2, v); chk("os_count", v, 32'(5 - k));
            chk("os_irq", {31'd0, IRQ}, (k == 5) ? 32'd1 : 32'd0);
            if (k < 5) tick();
        end
        tick();
        tick();
        chk("os_irq_held", {31'd0, IRQ}, 32'd1);
        rd(2'd0, v); chk("os_enable_cleared", v, 32'h8);
        wr(2'd0, 32'h8);
        chk("os_ack_irq", {31'd0, IRQ}, 32'd0);
        rd(2'd0, v); chk("os_ack_ctrl", v, 32'h8);

        // ---- mode 1, PRESET=3: pulses every 5 cycles, or one held IRQ ----
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 17; k++) begin
            tick();
`ifdef TIMER_MODE1_EN
            exp_irq = ((k % 5) == 0);
`else
            exp_irq = (k >= 5);
`endif
            chk("m1_irq", {31'd0, IRQ}, {31'd0, exp_irq});
        end
        rd(2'd0, v);
`ifdef TIMER_MODE1_EN
        chk("m1_ctrl", v, 32'hB);
`else
        chk("m1_ctrl", v, 32'hA);
`endif

        // ---- PRESET=0: IRQ at E0+3 ----
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        tick();
        chk("p0_irq_e2", {31'd0, IRQ}, 32'd0);
        tick();
        chk("p0_irq_e3", {31'd0, IRQ}, 32'd1);
        rd(2'd2, v); chk("p0_count", v, 32'd0);

        // ---- masked: flag sets, IRQ stays low ----
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 0; k < 5; k++) tick();
        chk("im0_flag", {31'd0, dut.r_flag}, 32'd1);
        chk("im0_irq", {31'd0, IRQ}, 32'd0);
        rd(2'd0, v); chk("im0_ctrl", v, 32'd0);
        wr(2'd0, 32'h8);
        chk("im0_ack_flag", {31'd0, dut.r_flag}, 32'd0);
        chk("im0_ack_irq", {31'd0, IRQ}, 32'd0);

        // ---- pause mid-count: disable lands on the edge COUNT becomes 4 ----
        do_reset();
        wr(2'd1, 32'd9);
        wr(2'd0, 32'h1);
        for (int k = 0; k < 6; k++) tick();
        rd(2'd2, v); chk("pause_pre", v, 32'd5);
        wr(2'd0, 32'h0);
        rd(2'd2, v); chk("pause_at", v, 32'd4);
        tick();
        tick();
        tick();
        rd(2'd2, v); chk("pause_frozen", v, 32'd4);
        chk("pause_idle", {30'd0, dut.r_state}, 32'd0);
        wr(2'd0, 32'h1);
        tick();
        rd(2'd2, v); chk("resume_e1", v, 32'd4);
        tick();
        rd(2'd2, v); chk("resume_reload", v, 32'd9);
        wr(2'd1, 32'd3);
        rd(2'd2, v); chk("preset_mid_cnt", v, 32'd8);
        tick();
        rd(2'd2, v); chk("preset_mid_cnt2", v, 32'd7);

        // ---- reset mid-count, ignored writes ----
        do_reset();
        wr(2'd1, 32'd12);
        wr(2'd0, 32'h9);
        for (int k = 0; k < 4; k++) tick();
        rd(2'd2, v); chk("rmid_pre", v, 32'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v); chk("rmid_reads", v, 32'd0);
        end
        chk("rmid_irq", {31'd0, IRQ}, 32'd0);
        wr(2'd2, 32'hFFFF);
        rd(2'd2, v); chk("count_ro", v, 32'd0);
        wr(2'd3, 32'h1234);
        rd(2'd3, v); chk("addr3_ro", v, 32'd0);
        tick();
        tick();
        rd(2'd2, v); chk("idle_stays", v, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
